sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Single-clock, parametrised pixel FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Next-generation buffer for same-domain stages of the data producer/processor path, where a clock crossing is not needed but back-pressure visibility and error reporting are. Optionally compiled as first-word-fall-through.

## Interface

Parameters:
- DATA_WIDTH, 8, width of one stored word (pixel)
- DEPTH, 32, number of entries; power of two, at least 4
- ADDR_WIDTH, 5, log2(DEPTH)
- AFULL_THRESH, DEPTH-4, almost_full asserts when count >= this value; range 1..DEPTH
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value; range 0..DEPTH-1

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of contents and error flags
- wr_en  input  1  write request
- wr_data  input  DATA_WIDTH  write word
- full  output  1  count == DEPTH
- almost_full  output  1  count >= AFULL_THRESH
- rd_en  input  1  read request
- rd_data  output  DATA_WIDTH  read word (timing depends on mode)
- empty  output  1  count == 0
- almost_empty  output  1  count <= AEMPTY_THRESH
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation

- Storage: DEPTH x DATA_WIDTH array; wr_ptr, rd_ptr are ADDR_WIDTH bits, wrap naturally from DEPTH-1 to 0.
- Write accepted = wr_en && !full && !flush: mem[wr_ptr] <= wr_data, wr_ptr increments.
- Read accepted = rd_en && !empty && !flush: rd_ptr increments.
- count: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted. Simultaneous read and write at any non-boundary occupancy: both accepted, count unchanged.
- Full: write rejected even if a read is accepted the same cycle. Empty: read rejected even if a write is accepted the same cycle.
- full, empty, almost_full, almost_empty decoded combinationally from registered count only.
- overflow set on wr_en && full && !flush; underflow set on rd_en && empty && !flush. Both hold until flush or reset. Rejected requests change no other state.
- flush: pointers and count to 0, overflow/underflow to 0; wr_en/rd_en ignored that cycle. Memory contents not cleared. rd_data holds its value (registered mode).
- Reset: wr_ptr, rd_ptr, count = 0; overflow, underflow = 0; rd_data = 0 (registered mode); so empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_THRESH >= 1).

## Timing

- Write latency: word written at edge N is counted after edge N; empty deasserts in cycle N+1.
- Registered mode: rd_data <= mem[rd_ptr] on the edge that accepts a read; valid from the cycle after rd_en, held until the next accepted read.
- Flags and count update on the same edge as the pointer change; no extra pipeline stage.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

## Configuration

- FIFO_FWFT_EN defined: first-word-fall-through. rd_data = mem[rd_ptr] combinationally; head word visible whenever empty=0; rd_en acknowledges (pops) the shown word. rd_data is don't-care while empty.
- FIFO_FWFT_EN undefined: registered read as described above; rd_data reset value 0.
- Count, flags, flush and error behaviour identical in both modes.

## Test plan

- DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2: write 0x01..0x08 -> count 1..8; almost_empty drops at count 3, almost_full rises at count 6, full=1 at count 8.
- Full, then wr_en with 0xAA -> overflow=1, count stays 8, 0xAA never read; drain 8 reads -> 0x01..0x08 in order, empty=1.
- Empty, rd_en -> underflow=1, count 0, rd_data unchanged; then flush -> underflow=0, overflow=0.
- Count=4, wr_en and rd_en together for 20 cycles with incrementing data -> count stays 4, pointers wrap, output order exact.
- Count=5, flush with wr_en=rd_en=1 -> count=0, empty=1, no write stored; next write 0x3C read back as 0x3C.
- Assert rst_n low between edges at count=3 -> count=0, empty=1, flags cleared immediately; FWFT build: single write 0x55 -> rd_data=0x55 in the cycle empty drops, before any rd_en.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost flags, sticky errors and flush.
// Read mode: define FIFO_FWFT_EN for first-word-fall-through; default is registered read.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Handshake: wr_en is valid and !full is ready; a word moves when both are high and
    // flush is low. Reads mirror this with rd_en as valid and !empty as ready.
    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_CNT);
    assign almost_empty = (count <= AEMPTY_CNT);

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; rd_en pops the word already on rd_data.
    assign rd_data = mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_acc) begin
            rd_data <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (DEPTH=8, AFULL=6, AEMPTY=2): vector table plus corner sequences.
module tb_sync_fifo_flags;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .DEPTH(8), .ADDR_WIDTH(AW), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          wr, rd, fl;
        logic [DW-1:0] d;
        logic [AW:0]   cnt;
        logic          full, empty, af, ae, ovf, unf, chk;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic wr, logic rd, logic fl, logic [DW-1:0] d, logic [AW:0] cnt,
                                logic f, logic e, logic af, logic ae, logic ovf, logic unf,
                                logic chk, logic [DW-1:0] exp_d);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.d = d; v.cnt = cnt;
        v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
        v.chk = chk; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [AW:0] cnt, input logic f, input logic e,
                               input logic af, input logic ae, input logic ovf, input logic unf);
        check({tag, "_count"}, 32'(count), 32'(cnt));
        check({tag, "_flags"}, {26'd0, full, empty, almost_full, almost_empty, overflow, underflow},
              {26'd0, f, e, af, ae, ovf, unf});
    endtask

    // driver: one clock of stimulus; read data checked where each mode presents the popped word
    task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] d,
                        input logic chk, input logic [DW-1:0] exp_d, input string tag);
        @(negedge clk);
        wr_en = w; rd_en = r; flush = f; wr_data = d;
`ifdef FIFO_FWFT_EN
        #1;
        if (chk) check({tag, "_rd_data"}, 32'(rd_data), 32'(exp_d));
`endif
        @(posedge clk);
        #1;
`ifndef FIFO_FWFT_EN
        if (chk) check({tag, "_rd_data"}, 32'(rd_data), 32'(exp_d));
`endif
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        step(1'b1, 1'b0, 1'b0, d, 1'b0, '0, "push");
        exp_q.push_back(d);
    endtask

    task automatic pop(input string tag);
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, e, tag);
    endtask

    initial begin
        //            wr rd fl data   cnt full empty af ae ovf unf chk exp
        vecs[0]  = mk(1, 0, 0, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        vecs[1]  = mk(1, 0, 0, 8'h02, 2, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        vecs[2]  = mk(1, 0, 0, 8'h03, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        vecs[3]  = mk(1, 0, 0, 8'h04, 4, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        vecs[4]  = mk(1, 0, 0, 8'h05, 5, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        vecs[5]  = mk(1, 0, 0, 8'h06, 6, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        vecs[6]  = mk(1, 0, 0, 8'h07, 7, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        vecs[7]  = mk(1, 0, 0, 8'h08, 8, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        vecs[8]  = mk(1, 0, 0, 8'hAA, 8, 1, 0, 1, 0, 1, 0, 0, 8'h00);
        vecs[9]  = mk(1, 1, 0, 8'hBB, 7, 0, 0, 1, 0, 1, 0, 1, 8'h01);
        vecs[10] = mk(0, 1, 0, 8'h00, 6, 0, 0, 1, 0, 1, 0, 1, 8'h02);
        vecs[11] = mk(0, 1, 0, 8'h00, 5, 0, 0, 0, 0, 1, 0, 1, 8'h03);
        vecs[12] = mk(0, 1, 0, 8'h00, 4, 0, 0, 0, 0, 1, 0, 1, 8'h04);
        vecs[13] = mk(0, 1, 0, 8'h00, 3, 0, 0, 0, 0, 1, 0, 1, 8'h05);
        vecs[14] = mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 1, 1, 0, 1, 8'h06);
        vecs[15] = mk(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h07);
        vecs[16] = mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 1, 8'h08);
        vecs[17] = mk(1, 1, 0, 8'h11, 1, 0, 0, 0, 1, 1, 1, 0, 8'h00);
        vecs[18] = mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00);

        // reset
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_flags("reset", 0, 0, 1, 0, 1, 0, 0);
`ifndef FIFO_FWFT_EN
        check("reset_rd_data", 32'(rd_data), 32'h0);
`endif

        // table: fill, overflow, write-at-full-with-read, drain, read-at-empty-with-write, flush
        for (int i = 0; i < 19; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].d, vecs[i].chk, vecs[i].exp_d, tag);
            check_flags(tag, vecs[i].cnt, vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae,
                        vecs[i].ovf, vecs[i].unf);
        end

        // underflow on plain read at empty; registered rd_data must hold the last popped word
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, "unf");
        check_flags("unf", 0, 0, 1, 0, 1, 0, 1);
`ifndef FIFO_FWFT_EN
        check("unf_rd_hold", 32'(rd_data), 32'h08);
`endif
        step(1'b0, 1'b0, 1'b1, '0, 1'b0, '0, "unf_flush");
        check_flags("unf_flush", 0, 0, 1, 0, 1, 0, 0);

        // steady state at count 4 with simultaneous read/write; pointers wrap several times
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            logic [DW-1:0] d, e;
            d = 8'(8'h60 + i);
            e = exp_q.pop_front();
            step(1'b1, 1'b1, 1'b0, d, 1'b1, e, $sformatf("rw%0d", i));
            exp_q.push_back(d);
            check($sformatf("rw%0d_count", i), 32'(count), 32'd4);
        end
        for (int i = 0; i < 4; i++) pop($sformatf("rwdrain%0d", i));
        check_flags("rwdrain", 0, 0, 1, 0, 1, 0, 0);

        // flush with both requests high at count 5: nothing stored, nothing popped
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
        check("pre_flush_count", 32'(count), 32'd5);
        step(1'b1, 1'b1, 1'b1, 8'h99, 1'b0, '0, "flush5");
        exp_q.delete();
        check_flags("flush5", 0, 0, 1, 0, 1, 0, 0);
        push(8'h3C);
        check_flags("after_flush_wr", 1, 0, 0, 0, 1, 0, 0);
        pop("after_flush_rd");
        check_flags("after_flush_rd", 0, 0, 1, 0, 1, 0, 0);

        // asynchronous reset mid-cycle at count 3 with underflow set
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, "pre_rst_unf");
        for (int i = 0; i < 3; i++) push(8'(8'h80 + i));
        check_flags("pre_rst", 3, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("async_rst", 0, 0, 1, 0, 1, 0, 0);
`ifndef FIFO_FWFT_EN
        check("async_rst_rd_data", 32'(rd_data), 32'h0);
`endif
        #1;
        rst_n = 1'b1;
        exp_q.delete();

        // single write; in FWFT the word must be visible before any rd_en
        push(8'h55);
        check_flags("single_wr", 1, 0, 0, 0, 1, 0, 0);
`ifdef FIFO_FWFT_EN
        check("fwft_head", 32'(rd_data), 32'h55);
`endif
        pop("single_rd");
        check_flags("single_rd", 0, 0, 1, 0, 1, 0, 0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
